// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Purpose  : Main control decoder and hazard sequencer for a 5-stage RISC-V
//             pipeline. Decodes the ID instruction into a control bundle,
//             owns the ID/EX control register, detects load-use hazards and
//             multi-cycle multiply occupancy of EX, and applies branch/jump
//             flushes.
//  Ports    : clk, reset_n (async, active-low)
//             ID_valid, Opcode, Funct7, Rs1, Rs2, Rd  - ID-stage fields
//             BranchTaken                             - EX redirect
//             EX_* (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
//                   Jump, Mul, ALUOp, Rd)             - registered ID/EX controls
//             PCWrite, IFIDWrite, IFIDFlush, EX_Busy  - pipeline steering
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_EN      = 1,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ID_valid,
    input  logic [6:0]            Opcode,
    input  logic [6:0]            Funct7,
    input  logic [REG_ADDR_W-1:0] Rs1,
    input  logic [REG_ADDR_W-1:0] Rs2,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic                  BranchTaken,
    output logic                  EX_ALUSrc,
    output logic                  EX_MemtoReg,
    output logic                  EX_RegWrite,
    output logic                  EX_MemRead,
    output logic                  EX_MemWrite,
    output logic                  EX_Branch,
    output logic                  EX_Jump,
    output logic                  EX_Mul,
    output logic [1:0]            EX_ALUOp,
    output logic [REG_ADDR_W-1:0] EX_Rd,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic                  EX_Busy
);

    localparam int CNT_W = $clog2(MUL_LATENCY) + 1;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_MUL_HOLD = 1'b1;

    localparam logic             c_MUL_EN    = (MUL_EN != 0);
    localparam logic             c_MUL_MULTI = (MUL_LATENCY > 1);
    // Only meaningful when c_MUL_MULTI; the entry cycle is already one hold cycle.
    localparam logic [CNT_W-1:0] c_CNT_INIT  = CNT_W'(MUL_LATENCY - 2);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_is_load, w_is_store, w_is_opimm, w_is_op, w_is_branch;
    logic w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_known;
    logic w_alusrc, w_memtoreg, w_regwrite, w_memread, w_memwrite;
    logic w_branch, w_jump, w_mul;
    logic [1:0]            w_aluop;
    logic [REG_ADDR_W-1:0] w_rd;
    logic w_uses_rs1, w_uses_rs2;

    always_comb begin
        w_is_load   = ID_valid && (Opcode == c_OP_LOAD);
        w_is_store  = ID_valid && (Opcode == c_OP_STORE);
        w_is_opimm  = ID_valid && (Opcode == c_OP_OPIMM);
        w_is_op     = ID_valid && (Opcode == c_OP_OP);
        w_is_branch = ID_valid && (Opcode == c_OP_BRANCH);
        w_is_lui    = ID_valid && (Opcode == c_OP_LUI);
        w_is_auipc  = ID_valid && (Opcode == c_OP_AUIPC);
        w_is_jal    = ID_valid && (Opcode == c_OP_JAL);
        w_is_jalr   = ID_valid && (Opcode == c_OP_JALR);
        w_known     = w_is_load | w_is_store | w_is_opimm | w_is_op | w_is_branch |
                      w_is_lui | w_is_auipc | w_is_jal | w_is_jalr;

        w_alusrc    = w_is_load | w_is_store | w_is_opimm | w_is_jalr | w_is_lui | w_is_auipc;
        w_regwrite  = w_is_op | w_is_opimm | w_is_load | w_is_jal | w_is_jalr |
                      w_is_lui | w_is_auipc;
        w_memread   = w_is_load;
        w_memtoreg  = w_is_load;
        w_memwrite  = w_is_store;
        w_branch    = w_is_branch;
        w_jump      = w_is_jal | w_is_jalr;
        w_mul       = c_MUL_EN && w_is_op && (Funct7 == c_F7_MULDIV);

        w_aluop = 2'b00;
        if (w_is_branch)     w_aluop = 2'b01;
        else if (w_is_op)    w_aluop = 2'b10;
        else if (w_is_opimm) w_aluop = 2'b11;

        w_rd       = w_known ? Rd : '0;
        w_uses_rs1 = w_known & ~(w_is_lui | w_is_auipc | w_is_jal);
        w_uses_rs2 = w_is_op | w_is_branch | w_is_store;
    end

    // ------------------------------------------------------------------
    // Hazards and sequencing
    // ------------------------------------------------------------------
    logic w_load_use, w_mul_start, w_hold, w_stall;
    logic w_ex_en, w_ex_bubble;

    always_comb begin
        w_load_use  = EX_MemRead && (EX_Rd != '0) &&
                      ((w_uses_rs1 && (Rs1 == EX_Rd)) || (w_uses_rs2 && (Rs2 == EX_Rd)));
        w_mul_start = c_MUL_MULTI && (r_state == c_ST_RUN) && EX_Mul;
        // A redirect always overrides the multiply hold.
        w_hold      = !BranchTaken &&
                      (w_mul_start || ((r_state == c_ST_MUL_HOLD) && (r_cnt != '0)));
        w_stall     = !BranchTaken && (w_hold || w_load_use);
        w_ex_en     = BranchTaken || !w_hold;
        w_ex_bubble = BranchTaken || w_load_use;
    end

    assign PCWrite   = !w_stall;
    assign IFIDWrite = !w_stall;
    assign IFIDFlush = BranchTaken;
    assign EX_Busy   = w_hold;

    // ------------------------------------------------------------------
    // FSM and ID/EX control register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_ST_RUN;
            r_cnt       <= '0;
            EX_ALUSrc   <= 1'b0;
            EX_MemtoReg <= 1'b0;
            EX_RegWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
            EX_Branch   <= 1'b0;
            EX_Jump     <= 1'b0;
            EX_Mul      <= 1'b0;
            EX_ALUOp    <= 2'b00;
            EX_Rd       <= '0;
        end else begin
            if (BranchTaken) begin
                r_state <= c_ST_RUN;
                r_cnt   <= '0;
            end else if (r_state == c_ST_RUN) begin
                if (w_mul_start) begin
                    r_state <= c_ST_MUL_HOLD;
                    r_cnt   <= c_CNT_INIT;
                end
            end else begin
                // cnt==0 is the final EX cycle of the multiply: no hold,
                // and the next instruction loads at this edge.
                if (r_cnt == '0) r_state <= c_ST_RUN;
                else             r_cnt   <= r_cnt - CNT_W'(1);
            end

            if (w_ex_en) begin
                EX_ALUSrc   <= w_alusrc   & ~w_ex_bubble;
                EX_MemtoReg <= w_memtoreg & ~w_ex_bubble;
                EX_RegWrite <= w_regwrite & ~w_ex_bubble;
                EX_MemRead  <= w_memread  & ~w_ex_bubble;
                EX_MemWrite <= w_memwrite & ~w_ex_bubble;
                EX_Branch   <= w_branch   & ~w_ex_bubble;
                EX_Jump     <= w_jump     & ~w_ex_bubble;
                EX_Mul      <= w_mul      & ~w_ex_bubble;
                EX_ALUOp    <= w_ex_bubble ? 2'b00 : w_aluop;
                EX_Rd       <= w_ex_bubble ? '0 : w_rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl_unit
//  Purpose  : Scoreboard bench for pipe_ctrl_unit. Two instances share the
//             stimulus: one with multiply decode enabled, one without. A
//             transaction-level model predicts each cycle's outputs; a
//             separate monitor compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam int LAT = 3;

    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_BAD    = 7'b1111111;

    typedef struct packed {
        logic       alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, mul;
        logic [1:0] aluop;
        logic [4:0] rd;
    } ctl_t;

    typedef struct packed {
        ctl_t ex;
        logic pcw, ifidw, flush, busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ID_valid = 1'b0;
    logic       BranchTaken = 1'b0;
    logic [6:0] Opcode = '0, Funct7 = '0;
    logic [4:0] Rs1 = '0, Rs2 = '0, Rd = '0;

    always #5 clk = ~clk;

    logic a_alusrc, a_memtoreg, a_regwrite, a_memread, a_memwrite, a_branch, a_jump, a_mul;
    logic [1:0] a_aluop;
    logic [4:0] a_rd;
    logic a_pcw, a_ifidw, a_flush, a_busy;
    logic b_alusrc, b_memtoreg, b_regwrite, b_memread, b_memwrite, b_branch, b_jump, b_mul;
    logic [1:0] b_aluop;
    logic [4:0] b_rd;
    logic b_pcw, b_ifidw, b_flush, b_busy;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .MUL_EN(1), .MUL_LATENCY(LAT)) u_dut_mul (
        .clk(clk), .reset_n(reset_n), .ID_valid(ID_valid), .Opcode(Opcode), .Funct7(Funct7),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .BranchTaken(BranchTaken),
        .EX_ALUSrc(a_alusrc), .EX_MemtoReg(a_memtoreg), .EX_RegWrite(a_regwrite),
        .EX_MemRead(a_memread), .EX_MemWrite(a_memwrite), .EX_Branch(a_branch),
        .EX_Jump(a_jump), .EX_Mul(a_mul), .EX_ALUOp(a_aluop), .EX_Rd(a_rd),
        .PCWrite(a_pcw), .IFIDWrite(a_ifidw), .IFIDFlush(a_flush), .EX_Busy(a_busy)
    );

    pipe_ctrl_unit #(.REG_ADDR_W(5), .MUL_EN(0), .MUL_LATENCY(LAT)) u_dut_nomul (
        .clk(clk), .reset_n(reset_n), .ID_valid(ID_valid), .Opcode(Opcode), .Funct7(Funct7),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .BranchTaken(BranchTaken),
        .EX_ALUSrc(b_alusrc), .EX_MemtoReg(b_memtoreg), .EX_RegWrite(b_regwrite),
        .EX_MemRead(b_memread), .EX_MemWrite(b_memwrite), .EX_Branch(b_branch),
        .EX_Jump(b_jump), .EX_Mul(b_mul), .EX_ALUOp(b_aluop), .EX_Rd(b_rd),
        .PCWrite(b_pcw), .IFIDWrite(b_ifidw), .IFIDFlush(b_flush), .EX_Busy(b_busy)
    );

    obs_t a_obs, b_obs;
    assign a_obs = {a_alusrc, a_memtoreg, a_regwrite, a_memread, a_memwrite, a_branch,
                    a_jump, a_mul, a_aluop, a_rd, a_pcw, a_ifidw, a_flush, a_busy};
    assign b_obs = {b_alusrc, b_memtoreg, b_regwrite, b_memread, b_memwrite, b_branch,
                    b_jump, b_mul, b_aluop, b_rd, b_pcw, b_ifidw, b_flush, b_busy};

    obs_t exp0_q[$];
    obs_t exp1_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   stalled = 1'b0;

    // ---------------- reference model ----------------
    // m_age counts how many cycles the current EX occupant has spent in EX.
    ctl_t m_ex [2];
    int   m_age[2];
    bit   m_mul_en[2] = '{1'b1, 1'b0};

    function automatic ctl_t decode(logic v, logic [6:0] op, logic [6:0] f7,
                                    logic [4:0] rd, bit mul_en);
        ctl_t c = '0;
        if (!v) return c;
        case (op)
            c_OP:     begin c.regwrite = 1; c.aluop = 2'd2; c.mul = mul_en && (f7 == 7'b0000001); end
            c_OPIMM:  begin c.regwrite = 1; c.alusrc = 1; c.aluop = 2'd3; end
            c_LOAD:   begin c.regwrite = 1; c.alusrc = 1; c.memread = 1; c.memtoreg = 1; end
            c_STORE:  begin c.alusrc = 1; c.memwrite = 1; end
            c_BRANCH: begin c.branch = 1; c.aluop = 2'd1; end
            c_LUI,
            c_AUIPC:  begin c.regwrite = 1; c.alusrc = 1; end
            c_JAL:    begin c.regwrite = 1; c.jump = 1; end
            c_JALR:   begin c.regwrite = 1; c.jump = 1; c.alusrc = 1; end
            default:  return c;
        endcase
        c.rd = rd;
        return c;
    endfunction

    function automatic bit reads_rs1(logic v, logic [6:0] op);
        return v && (op == c_OP || op == c_OPIMM || op == c_LOAD || op == c_STORE ||
                     op == c_BRANCH || op == c_JALR);
    endfunction

    function automatic bit reads_rs2(logic v, logic [6:0] op);
        return v && (op == c_OP || op == c_BRANCH || op == c_STORE);
    endfunction

    task automatic model_cycle(input int k, input logic v, input logic [6:0] op,
                               input logic [6:0] f7, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic bt, input logic rst_a, output obs_t o);
        ctl_t d;
        bit   hold, lu;
        o = '0;
        if (rst_a) begin
            m_ex[k]  = '0;
            m_age[k] = 1;
            o.pcw    = 1'b1;
            o.ifidw  = 1'b1;
            return;
        end
        o.ex = m_ex[k];
        d    = decode(v, op, f7, rd, m_mul_en[k]);
        hold = m_ex[k].mul && (m_age[k] < LAT);
        lu   = m_ex[k].memread && (m_ex[k].rd != 0) &&
               ((reads_rs1(v, op) && rs1 == m_ex[k].rd) ||
                (reads_rs2(v, op) && rs2 == m_ex[k].rd));
        if (bt) begin
            o.flush = 1; o.pcw = 1; o.ifidw = 1;
            m_ex[k] = '0; m_age[k] = 1;
        end else if (hold) begin
            o.busy = 1;
            m_age[k] = m_age[k] + 1;
        end else if (lu) begin
            m_ex[k] = '0; m_age[k] = 1;
        end else begin
            o.pcw = 1; o.ifidw = 1;
            m_ex[k] = d; m_age[k] = 1;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [6:0] op, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic bt, input logic rst_a);
        obs_t o0, o1;
        @(negedge clk);
        reset_n     = !rst_a;
        ID_valid    = v;
        Opcode      = op;
        Funct7      = f7;
        Rs1         = rs1;
        Rs2         = rs2;
        Rd          = rd;
        BranchTaken = bt;
        model_cycle(0, v, op, f7, rs1, rs2, rd, bt, rst_a, o0);
        model_cycle(1, v, op, f7, rs1, rs2, rd, bt, rst_a, o1);
        exp0_q.push_back(o0);
        exp1_q.push_back(o1);
        stalled = !o0.flush && !o0.ifidw;
        cyc++;
    endtask

    // Presents an instruction and keeps it in ID while the pipeline holds IF/ID.
    task automatic issue(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        step(1'b1, op, f7, rs1, rs2, rd, 1'b0, 1'b0);
        for (int n = 0; n < 8 && stalled; n++)
            step(1'b1, op, f7, rs1, rs2, rd, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                checks++;
                if (a_obs !== e) begin
                    errors++;
                    $display("FAIL mul_en1 cyc %0d: got %h required %h", cyc, a_obs, e);
                end
            end
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                checks++;
                if (b_obs !== e) begin
                    errors++;
                    $display("FAIL mul_en0 cyc %0d: got %h required %h", cyc, b_obs, e);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    logic [6:0] ops[10] = '{c_LOAD, c_STORE, c_OPIMM, c_OP, c_BRANCH,
                             c_LUI, c_AUIPC, c_JAL, c_JALR, c_BAD};

    initial begin
        logic       rv, rbt;
        logic [6:0] rop, rf7;
        logic [4:0] r1, r2, rdd;

        step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);

        // Plain decode: add x7, then addi x3
        issue(c_OP,    7'd0, 5'd1, 5'd2, 5'd7);
        issue(c_OPIMM, 7'd0, 5'd1, 5'd0, 5'd3);
        // Load-use: lw x5 ; add x6,x5,x1
        issue(c_LOAD,  7'd0, 5'd2, 5'd0, 5'd5);
        issue(c_OP,    7'd0, 5'd5, 5'd1, 5'd6);
        // lw to x0 must not stall
        issue(c_LOAD,  7'd0, 5'd2, 5'd0, 5'd0);
        issue(c_OP,    7'd0, 5'd0, 5'd0, 5'd6);
        // LUI with rs1 field matching the load target must not stall
        issue(c_LOAD,  7'd0, 5'd2, 5'd0, 5'd5);
        issue(c_LUI,   7'd0, 5'd5, 5'd5, 5'd8);
        // Multiply occupancy, then the following instruction
        issue(c_OP,    7'b0000001, 5'd1, 5'd2, 5'd9);
        issue(c_OP,    7'd0, 5'd9, 5'd1, 5'd10);
        issue(c_OPIMM, 7'd0, 5'd1, 5'd0, 5'd11);
        // Branch taken while a load-use condition is present
        issue(c_LOAD,  7'd0, 5'd2, 5'd0, 5'd5);
        step(1'b1, c_OP, 7'd0, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        issue(c_OP,    7'd0, 5'd5, 5'd1, 5'd6);
        // Reset asserted while a multiply is holding EX
        issue(c_OP,    7'b0000001, 5'd1, 5'd2, 5'd12);
        step(1'b1, c_OP, 7'd0, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0);
        step(1'b1, c_OP, 7'd0, 5'd1, 5'd2, 5'd13, 1'b0, 1'b1);
        step(1'b1, c_OP, 7'd0, 5'd1, 5'd2, 5'd13, 1'b0, 1'b1);
        issue(c_OP,    7'd0, 5'd1, 5'd2, 5'd13);

        // Randomised traffic
        rv = 1'b1; rop = c_OP; rf7 = '0; r1 = '0; r2 = '0; rdd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!stalled) begin
                rv  = ($urandom_range(0, 9) != 0);
                rop = ops[$urandom_range(0, 9)];
                rf7 = ($urandom_range(0, 2) == 0) ? 7'b0000001 :
                      (($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0);
                r1  = 5'($urandom_range(0, 5));
                r2  = 5'($urandom_range(0, 5));
                rdd = 5'($urandom_range(0, 5));
            end
            rbt = (m_ex[0].branch || m_ex[0].jump) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 79) == 0)
                step(rv, rop, rf7, r1, r2, rdd, 1'b0, 1'b1);
            else
                step(rv, rop, rf7, r1, r2, rdd, rbt, 1'b0);
        end

        for (int n = 0; n < 10 && (exp0_q.size() != 0 || exp1_q.size() != 0); n++)
            @(negedge clk);
        #3;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp0_q.size() + exp1_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Registered main control and hazard unit for the 5-stage RISC-V pipeline. It decodes the ID-stage instruction into a control bundle and owns the ID/EX control register. It detects load-use hazards and multi-cycle multiply occupancy in EX, applies branch/jump flushes, and drives the PC and IF/ID write-enable/flush lines. It succeeds the combinational main decoder by adding OP_IMM/LUI/AUIPC/JAL/JALR decode, a Jump signal, and a stall/flush sequencer.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- MUL_EN, 1, 1 = decode OP with Funct7=0000001 as multi-cycle multiply
- MUL_LATENCY, 3, cycles a multiply occupies EX (>=1; 1 = no hold)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ID_valid  in  1  IF/ID holds a real instruction
- Opcode  in  7  ID instruction [6:0]
- Funct7  in  7  ID instruction [31:25]
- Rs1, Rs2, Rd  in  REG_ADDR_W  ID register fields
- BranchTaken  in  1  EX redirect (taken branch or jump); valid only while EX holds a real instruction
- EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_Jump, EX_Mul  out  1  registered ID/EX controls
- EX_ALUOp  out  2  00 load/store/LUI/AUIPC/jumps, 01 branch, 10 OP, 11 OP_IMM
- EX_Rd  out  REG_ADDR_W  registered destination
- PCWrite, IFIDWrite  out  1  PC / IF/ID enables (0 = hold)
- IFIDFlush  out  1  clear IF/ID to a bubble
- EX_Busy  out  1  multiply hold in progress

## Operation
- Decode (combinational, from ID fields):
  - ALUSrc = LOAD|STORE|OP_IMM|JALR|LUI|AUIPC
  - RegWrite = OP|OP_IMM|LOAD|JAL|JALR|LUI|AUIPC
  - MemRead = MemtoReg = LOAD
  - MemWrite = STORE
  - Branch = BRANCH
  - Jump = JAL|JALR
  - Mul = MUL_EN & OP & Funct7==0000001
  - Unknown opcode or ID_valid=0 decodes as a bubble (all zeros, Rd=0).
- Register usage:
  - uses_rs1 = every valid opcode except LUI, AUIPC, JAL.
  - uses_rs2 = OP, BRANCH, STORE.
- Load-use hazard = EX_MemRead & EX_Rd!=0 & ((uses_rs1 & Rs1==EX_Rd) | (uses_rs2 & Rs2==EX_Rd)).
- FSM states are RUN and MUL_HOLD, with a counter cnt of width clog2(MUL_LATENCY)+1.
  - RUN, when EX_Mul=1 and MUL_LATENCY>1: enter MUL_HOLD next cycle with cnt=MUL_LATENCY-2 and assert a hold this cycle.
  - MUL_HOLD: assert the hold. When cnt==0, return to RUN and deassert the hold in that same cycle. Otherwise decrement cnt.
  - Hold: PCWrite=0, IFIDWrite=0, ID/EX register keeps its value, EX_Busy=1.
- Priority per cycle, highest first:
  1. BranchTaken: IFIDFlush=1, PCWrite=1, ID/EX loads a bubble.
  2. Mul hold.
  3. Load-use: PCWrite=0, IFIDWrite=0, ID/EX loads a bubble.
  4. Normal: ID/EX loads the decoded bundle.
- BranchTaken cannot coincide with EX_Mul=1, because a multiply never redirects; if it does, the flush wins and the FSM returns to RUN.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - all EX_* outputs 0, EX_Rd=0
  - state RUN, cnt=0
  - outputs read PCWrite=1, IFIDWrite=1, IFIDFlush=0, EX_Busy=0
  - Reset mid-hold or mid-stall abandons it immediately.
- PCWrite, IFIDWrite, IFIDFlush and EX_Busy are combinational from state, the EX_* registers and the current inputs.
- Decode-to-EX latency is 1 cycle.
- A load-use stall costs exactly 1 bubble. Next cycle EX_MemRead=0, so the hazard clears.
- A multiply keeps EX_* stable for MUL_LATENCY cycles total. The next instruction enters EX on the edge after the last hold cycle.
- A taken branch inserts 1 bubble into ID/EX and 1 into IF/ID; the 2-cycle penalty is owned by this block.

## Test plan
- Reset: drive reset_n=0 during MUL_HOLD -> EX_* outputs 0 asynchronously; PCWrite=1, EX_Busy=0; after release the FSM is in RUN.
- Decode: Opcode 0110011, Funct7=0, Rd=7 -> next cycle EX_RegWrite=1, EX_ALUOp=10, EX_ALUSrc=0, EX_Rd=7. Opcode 0010011 -> EX_ALUOp=11, EX_ALUSrc=1.
- Load-use: lw x5, then add x6,x5,x1 in ID -> one cycle with PCWrite=0, IFIDWrite=0, next EX bubble; add reaches EX one cycle later. The same sequence with an lw to rd=x0 -> no stall.
- LUI after lw x5 with instruction field Rs1=5 -> no stall, since LUI does not use rs1.
- Multiply, MUL_LATENCY=3: mul reaches EX -> EX_Busy=1 for 2 cycles (entry cycle plus one MUL_HOLD cycle), EX_* stable for 3 cycles, then the next instruction enters. With MUL_EN=0 the same encoding gives no hold.
- Branch taken in the same cycle as a load-use condition -> IFIDFlush=1, PCWrite=1, EX bubble; no stall cycle follows.
